// File: rtl/cpu_pkg.sv
// Shared datapath constants: widths, ALU function codes, operand-source selects
// and the hard-wired zero register index.
package cpu_pkg;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int FW = 6;

  localparam logic [FW-1:0] ALU_ADD = 6'b000000;
  localparam logic [FW-1:0] ALU_SUB = 6'b000001;
  localparam logic [FW-1:0] ALU_AND = 6'b011000;
  localparam logic [FW-1:0] ALU_OR  = 6'b011110;
  localparam logic [FW-1:0] ALU_XOR = 6'b010110;
  localparam logic [FW-1:0] ALU_NOR = 6'b010001;
  localparam logic [FW-1:0] ALU_SLL = 6'b100000;
  localparam logic [FW-1:0] ALU_SRL = 6'b100001;
  localparam logic [FW-1:0] ALU_SRA = 6'b100011;
  localparam logic [FW-1:0] ALU_EQ  = 6'b110011;

  localparam logic SRCA_RS    = 1'b0;
  localparam logic SRCA_SHAMT = 1'b1;
  localparam logic SRCB_RT    = 1'b0;
  localparam logic SRCB_IMM   = 1'b1;

  localparam logic [RW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bundle between the ID stage, the forwarding sources and the EX-stage operand
// registers. The slave side is the pipeline register; the master side drives it.
interface ex_operand_stage_if #(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW,
  parameter int FW = cpu_pkg::FW
);

  logic          stall;
  logic          flush;

  logic          id_valid;
  logic [RW-1:0] id_rs_addr;
  logic [RW-1:0] id_rt_addr;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic [4:0]    id_shamt;
  logic          id_srca;
  logic          id_srcb;
  logic [FW-1:0] id_alufun;
  logic          id_sign;
  logic [RW-1:0] id_wr_addr;

  logic          mem_wr_en;
  logic [RW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          wb_wr_en;
  logic [RW-1:0] wb_wr_addr;
  logic [DW-1:0] wb_wr_data;

  logic          ex_valid;
  logic [DW-1:0] ex_A;
  logic [DW-1:0] ex_B;
  logic [FW-1:0] ex_alufun;
  logic          ex_sign;
  logic [DW-1:0] ex_st_data;
  logic [RW-1:0] ex_wr_addr;

  modport master (
    output stall, flush,
    output id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
    output id_shamt, id_srca, id_srcb, id_alufun, id_sign, id_wr_addr,
    output mem_wr_en, mem_wr_addr, mem_wr_data, wb_wr_en, wb_wr_addr, wb_wr_data,
    input  ex_valid, ex_A, ex_B, ex_alufun, ex_sign, ex_st_data, ex_wr_addr
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data, id_imm,
    input  id_shamt, id_srca, id_srcb, id_alufun, id_sign, id_wr_addr,
    input  mem_wr_en, mem_wr_addr, mem_wr_data, wb_wr_en, wb_wr_addr, wb_wr_data,
    output ex_valid, ex_A, ex_B, ex_alufun, ex_sign, ex_st_data, ex_wr_addr
  );

endinterface

// File: rtl/fwd_mux.sv
// Three-way priority forward select for one source register: EX/MEM result,
// then MEM/WB result, then the register-file read. $0 never forwards.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW
) (
  input  logic [RW-1:0] addr,
  input  logic [DW-1:0] rf_data,
  input  logic          mem_wr_en,
  input  logic [RW-1:0] mem_wr_addr,
  input  logic [DW-1:0] mem_wr_data,
  input  logic          wb_wr_en,
  input  logic [RW-1:0] wb_wr_addr,
  input  logic [DW-1:0] wb_wr_data,
  output logic [DW-1:0] data
);

  logic not_zero;
  logic mem_hit;
  logic wb_hit;

  assign not_zero = (addr != RW'(REG_ZERO));
  assign mem_hit  = mem_wr_en && (mem_wr_addr == addr) && not_zero;
  assign wb_hit   = wb_wr_en && (wb_wr_addr == addr) && not_zero;

  // The younger producer (EX/MEM) wins when both stages target the same register.
  always_comb begin
    data = rf_data;
    if (mem_hit) begin
      data = mem_wr_data;
    end else if (wb_hit) begin
      data = wb_wr_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register: forwards rs/rt, selects ALU operands and registers the
// A/B/ALUFun/Sign bundle for EX, honouring stall and flush from the hazard unit.
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW,
  parameter int FW = cpu_pkg::FW
) (
  input logic clk,
  input logic reset,
  ex_operand_stage_if.slave bus
);

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic [DW-1:0] a_next;
  logic [DW-1:0] b_next;

  logic          valid_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [FW-1:0] alufun_q;
  logic          sign_q;
  logic [DW-1:0] st_data_q;
  logic [RW-1:0] wr_addr_q;

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .addr        (bus.id_rs_addr),
    .rf_data     (bus.id_rs_data),
    .mem_wr_en   (bus.mem_wr_en),
    .mem_wr_addr (bus.mem_wr_addr),
    .mem_wr_data (bus.mem_wr_data),
    .wb_wr_en    (bus.wb_wr_en),
    .wb_wr_addr  (bus.wb_wr_addr),
    .wb_wr_data  (bus.wb_wr_data),
    .data        (fwd_rs)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .addr        (bus.id_rt_addr),
    .rf_data     (bus.id_rt_data),
    .mem_wr_en   (bus.mem_wr_en),
    .mem_wr_addr (bus.mem_wr_addr),
    .mem_wr_data (bus.mem_wr_data),
    .wb_wr_en    (bus.wb_wr_en),
    .wb_wr_addr  (bus.wb_wr_addr),
    .wb_wr_data  (bus.wb_wr_data),
    .data        (fwd_rt)
  );

  assign a_next = (bus.id_srca == SRCA_SHAMT) ? {{(DW-5){1'b0}}, bus.id_shamt} : fwd_rs;
  assign b_next = (bus.id_srcb == SRCB_IMM) ? bus.id_imm : fwd_rt;

  // Flush beats stall: a flushed slot only needs its control fields cleared, so
  // the data registers are left free to capture whatever is presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      alufun_q  <= '0;
      sign_q    <= 1'b0;
      st_data_q <= '0;
      wr_addr_q <= '0;
    end else if (bus.flush) begin
      valid_q   <= 1'b0;
      wr_addr_q <= '0;
      alufun_q  <= '0;
      sign_q    <= 1'b0;
      a_q       <= a_next;
      b_q       <= b_next;
      st_data_q <= fwd_rt;
    end else if (!bus.stall) begin
      valid_q   <= bus.id_valid;
      wr_addr_q <= bus.id_valid ? bus.id_wr_addr : '0;
      alufun_q  <= bus.id_alufun;
      sign_q    <= bus.id_sign;
      a_q       <= a_next;
      b_q       <= b_next;
      st_data_q <= fwd_rt;
    end
  end

  assign bus.ex_valid   = valid_q;
  assign bus.ex_A       = a_q;
  assign bus.ex_B       = b_q;
  assign bus.ex_alufun  = alufun_q;
  assign bus.ex_sign    = sign_q;
  assign bus.ex_st_data = st_data_q;
  assign bus.ex_wr_addr = wr_addr_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage: reset, forwarding priority, $0,
// immediate/store data, stall/flush and shift operand, each with hand-computed values.
module tb_ex_operand_stage;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  ex_operand_stage_if bus ();

  ex_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and sample just after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset            = 1'b0;
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;
    bus.id_valid     = 1'b1;
    bus.id_rs_addr   = 5'd1;
    bus.id_rt_addr   = 5'd2;
    bus.id_rs_data   = 32'h0000_0011;
    bus.id_rt_data   = 32'h0000_0022;
    bus.id_imm       = 32'h0;
    bus.id_shamt     = 5'd0;
    bus.id_srca      = SRCA_RS;
    bus.id_srcb      = SRCB_RT;
    bus.id_alufun    = ALU_SUB;
    bus.id_sign      = 1'b1;
    bus.id_wr_addr   = 5'd7;
    bus.mem_wr_en    = 1'b0;
    bus.mem_wr_addr  = 5'd0;
    bus.mem_wr_data  = 32'h0;
    bus.wb_wr_en     = 1'b0;
    bus.wb_wr_addr   = 5'd0;
    bus.wb_wr_data   = 32'h0;

    // 1. Reset held with a valid ID bundle and a running clock.
    applyStimulus();
    applyStimulus();
    checkOutput("rst_valid",   32'(bus.ex_valid),   32'd0);
    checkOutput("rst_A",       bus.ex_A,            32'd0);
    checkOutput("rst_B",       bus.ex_B,            32'd0);
    checkOutput("rst_alufun",  32'(bus.ex_alufun),  32'd0);
    checkOutput("rst_sign",    32'(bus.ex_sign),    32'd0);
    checkOutput("rst_st_data", bus.ex_st_data,      32'd0);
    checkOutput("rst_wr_addr", 32'(bus.ex_wr_addr), 32'd0);

    reset = 1'b1;
    applyStimulus();
    checkOutput("load_valid",   32'(bus.ex_valid),   32'd1);
    checkOutput("load_A",       bus.ex_A,            32'h0000_0011);
    checkOutput("load_B",       bus.ex_B,            32'h0000_0022);
    checkOutput("load_st_data", bus.ex_st_data,      32'h0000_0022);
    checkOutput("load_alufun",  32'(bus.ex_alufun),  32'(ALU_SUB));
    checkOutput("load_sign",    32'(bus.ex_sign),    32'd1);
    checkOutput("load_wr_addr", 32'(bus.ex_wr_addr), 32'd7);

    // 2. Both stages hit rs: EX/MEM wins; then only MEM/WB hits.
    bus.id_rs_addr  = 5'd5;
    bus.id_rs_data  = 32'h0000_0099;
    bus.id_rt_addr  = 5'd6;
    bus.id_rt_data  = 32'h0000_0066;
    bus.id_alufun   = ALU_ADD;
    bus.id_sign     = 1'b0;
    bus.mem_wr_en   = 1'b1;
    bus.mem_wr_addr = 5'd5;
    bus.mem_wr_data = 32'hAAAA_0000;
    bus.wb_wr_en    = 1'b1;
    bus.wb_wr_addr  = 5'd5;
    bus.wb_wr_data  = 32'h0000_5555;
    applyStimulus();
    checkOutput("dbl_fwd_A", bus.ex_A, 32'hAAAA_0000);
    checkOutput("dbl_fwd_B", bus.ex_B, 32'h0000_0066);

    bus.mem_wr_addr = 5'd4;
    applyStimulus();
    checkOutput("wb_fwd_A", bus.ex_A, 32'h0000_5555);

    bus.mem_wr_en = 1'b0;
    bus.wb_wr_en  = 1'b0;
    applyStimulus();
    checkOutput("no_fwd_A", bus.ex_A, 32'h0000_0099);

    // 3. $0 never forwards even with matching, enabled writers.
    bus.id_rt_addr  = 5'd0;
    bus.id_rt_data  = 32'h0;
    bus.mem_wr_en   = 1'b1;
    bus.mem_wr_addr = 5'd0;
    bus.mem_wr_data = 32'hFFFF_FFFF;
    bus.wb_wr_en    = 1'b1;
    bus.wb_wr_addr  = 5'd0;
    bus.wb_wr_data  = 32'h0000_DEAD;
    applyStimulus();
    checkOutput("zero_B",       bus.ex_B,       32'h0);
    checkOutput("zero_st_data", bus.ex_st_data, 32'h0);

    // 4. Immediate on B while store data still carries the forwarded rt.
    bus.id_rs_addr  = 5'd1;
    bus.id_rs_data  = 32'h0000_0011;
    bus.id_rt_addr  = 5'd3;
    bus.id_rt_data  = 32'h0000_0077;
    bus.id_srcb     = SRCB_IMM;
    bus.id_imm      = 32'hFFFF_FFFC;
    bus.id_alufun   = ALU_AND;
    bus.id_wr_addr  = 5'd4;
    bus.mem_wr_addr = 5'd8;
    bus.wb_wr_addr  = 5'd3;
    bus.wb_wr_data  = 32'h0000_1234;
    applyStimulus();
    checkOutput("imm_B",       bus.ex_B,       32'hFFFF_FFFC);
    checkOutput("imm_st_data", bus.ex_st_data, 32'h0000_1234);
    checkOutput("imm_A",       bus.ex_A,       32'h0000_0011);

    // 5. Three stalled edges with changing ID and forwarding inputs.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.id_valid   = 1'(i);
      bus.id_rs_data = 32'hC0DE_0000 + 32'(i);
      bus.id_srcb    = SRCB_RT;
      bus.id_wr_addr = 5'd20 + 5'(i);
      bus.id_alufun  = ALU_XOR;
      bus.id_sign    = 1'b1;
      bus.wb_wr_data = 32'hBEEF_0000 + 32'(i);
      applyStimulus();
      checkOutput($sformatf("stall%0d_A", i),       bus.ex_A,            32'h0000_0011);
      checkOutput($sformatf("stall%0d_B", i),       bus.ex_B,            32'hFFFF_FFFC);
      checkOutput($sformatf("stall%0d_st", i),      bus.ex_st_data,      32'h0000_1234);
      checkOutput($sformatf("stall%0d_valid", i),   32'(bus.ex_valid),   32'd1);
      checkOutput($sformatf("stall%0d_wr", i),      32'(bus.ex_wr_addr), 32'd4);
      checkOutput($sformatf("stall%0d_alufun", i),  32'(bus.ex_alufun),  32'(ALU_AND));
      checkOutput($sformatf("stall%0d_sign", i),    32'(bus.ex_sign),    32'd0);
    end

    bus.id_valid = 1'b1;
    bus.flush    = 1'b1;
    applyStimulus();
    checkOutput("flush_valid",  32'(bus.ex_valid),   32'd0);
    checkOutput("flush_wr",     32'(bus.ex_wr_addr), 32'd0);
    checkOutput("flush_alufun", 32'(bus.ex_alufun),  32'd0);
    checkOutput("flush_sign",   32'(bus.ex_sign),    32'd0);

    // 6. Shift amount zero-extended onto A; then an invalid slot.
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.mem_wr_en  = 1'b0;
    bus.wb_wr_en   = 1'b0;
    bus.id_srca    = SRCA_SHAMT;
    bus.id_shamt   = 5'd31;
    bus.id_rs_data = 32'hFFFF_FFFF;
    bus.id_alufun  = ALU_SLL;
    bus.id_sign    = 1'b0;
    bus.id_wr_addr = 5'd9;
    applyStimulus();
    checkOutput("shamt_A",      bus.ex_A,            32'd31);
    checkOutput("shamt_valid",  32'(bus.ex_valid),   32'd1);
    checkOutput("shamt_wr",     32'(bus.ex_wr_addr), 32'd9);
    checkOutput("shamt_alufun", 32'(bus.ex_alufun),  32'(ALU_SLL));

    bus.id_valid = 1'b0;
    applyStimulus();
    checkOutput("bubble_valid", 32'(bus.ex_valid),   32'd0);
    checkOutput("bubble_wr",    32'(bus.ex_wr_addr), 32'd0);
    checkOutput("bubble_A",     bus.ex_A,            32'd31);

    // Reset asserted between edges while stalled clears everything at once.
    bus.id_valid = 1'b1;
    applyStimulus();
    bus.stall = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(bus.ex_valid),   32'd0);
    checkOutput("async_rst_A",     bus.ex_A,            32'd0);
    checkOutput("async_rst_wr",    32'(bus.ex_wr_addr), 32'd0);
    checkOutput("async_rst_alu",   32'(bus.ex_alufun),  32'd0);
    reset = 1'b1;
    applyStimulus();
    checkOutput("post_rst_stall_valid", 32'(bus.ex_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
